// File: rtl/bus_split_arbiter_pkg.sv
// Shared bus definitions: arbiter state encoding and master identifiers.
package bus_split_arbiter_pkg;

  localparam logic [2:0] ENC_IDLE    = 3'd0;
  localparam logic [2:0] ENC_M1      = 3'd1;
  localparam logic [2:0] ENC_M2      = 3'd2;
  localparam logic [2:0] ENC_S1_IDLE = 3'd3;
  localparam logic [2:0] ENC_S1_M2   = 3'd4;
  localparam logic [2:0] ENC_S2_IDLE = 3'd5;
  localparam logic [2:0] ENC_S2_M1   = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE    = ENC_IDLE,
    ST_M1      = ENC_M1,
    ST_M2      = ENC_M2,
    ST_S1_IDLE = ENC_S1_IDLE,
    ST_S1_M2   = ENC_S1_M2,
    ST_S2_IDLE = ENC_S2_IDLE,
    ST_S2_M1   = ENC_S2_M1
  } arb_state_e;

  localparam logic MASTER_M1 = 1'b0;
  localparam logic MASTER_M2 = 1'b1;

  function automatic logic is_suspended(arb_state_e s);
    return (s == ST_S1_IDLE) || (s == ST_S1_M2) ||
           (s == ST_S2_IDLE) || (s == ST_S2_M1);
  endfunction

endpackage

// File: rtl/bus_split_arbiter.sv
// Two-master bus arbiter with round-robin arbitration, single split-transaction
// suspension and a suspension timeout. All outputs come straight from flops.
module bus_split_arbiter
  import bus_split_arbiter_pkg::*;
#(
  parameter int SPLIT_TIMEOUT = 4096,
  parameter int TWIDTH        = 13
) (
  input  logic clk,
  input  logic rstn,
  input  logic m1_breq,
  input  logic m2_breq,
  input  logic split,
  input  logic split_done,
  output logic m1_bgrant,
  output logic m2_bgrant,
  output logic msel,
  output logic m1_split,
  output logic m2_split,
  output logic split_grant,
  output logic split_timeout
);

  arb_state_e        state_q, state_d;
  logic [TWIDTH-1:0] cnt_q, cnt_d;
  logic              pend_q, pend_d;
  logic              last_q, last_d;
  logic              msel_q, msel_d;
  logic              m1_bgrant_q, m1_bgrant_d;
  logic              m2_bgrant_q, m2_bgrant_d;
  logic              m1_split_q, m1_split_d;
  logic              m2_split_q, m2_split_d;
  logic              split_grant_q, split_grant_d;
  logic              split_timeout_q, split_timeout_d;
  logic              expired;

  assign expired = (cnt_q == TWIDTH'(SPLIT_TIMEOUT - 1));

  // Timeout is checked before split_done so a coincident split_done is dropped.
  always_comb begin
    state_d         = state_q;
    pend_d          = pend_q;
    split_grant_d   = 1'b0;
    split_timeout_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (m1_breq && (!m2_breq || last_q == MASTER_M2)) state_d = ST_M1;
        else if (m2_breq)                                 state_d = ST_M2;
      end
      ST_M1: begin
        if (split)         state_d = ST_S1_IDLE;
        else if (!m1_breq) state_d = ST_IDLE;
      end
      ST_M2: begin
        if (split)         state_d = ST_S2_IDLE;
        else if (!m2_breq) state_d = ST_IDLE;
      end
      ST_S1_IDLE: begin
        if (expired) begin
          state_d         = ST_IDLE;
          split_timeout_d = 1'b1;
          pend_d          = 1'b0;
        end else if (split_done) begin
          state_d       = ST_M1;
          split_grant_d = 1'b1;
        end else if (m2_breq) begin
          state_d = ST_S1_M2;
        end
      end
      ST_S1_M2: begin
        if (expired) begin
          state_d         = ST_M2;
          split_timeout_d = 1'b1;
          pend_d          = 1'b0;
        end else if (!m2_breq && (pend_q || split_done)) begin
          state_d       = ST_M1;
          split_grant_d = 1'b1;
          pend_d        = 1'b0;
        end else if (!m2_breq) begin
          state_d = ST_S1_IDLE;
        end else if (split_done) begin
          pend_d = 1'b1;
        end
      end
      ST_S2_IDLE: begin
        if (expired) begin
          state_d         = ST_IDLE;
          split_timeout_d = 1'b1;
          pend_d          = 1'b0;
        end else if (split_done) begin
          state_d       = ST_M2;
          split_grant_d = 1'b1;
        end else if (m1_breq) begin
          state_d = ST_S2_M1;
        end
      end
      ST_S2_M1: begin
        if (expired) begin
          state_d         = ST_M1;
          split_timeout_d = 1'b1;
          pend_d          = 1'b0;
        end else if (!m1_breq && (pend_q || split_done)) begin
          state_d       = ST_M2;
          split_grant_d = 1'b1;
          pend_d        = 1'b0;
        end else if (!m1_breq) begin
          state_d = ST_S2_IDLE;
        end else if (split_done) begin
          pend_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The count spans the whole suspension, including hops between Sx_ states.
  always_comb begin
    cnt_d = '0;
    if (is_suspended(state_d) && is_suspended(state_q)) cnt_d = cnt_q + TWIDTH'(1);
  end

  always_comb begin
    m1_bgrant_d = (state_d == ST_M1) || (state_d == ST_S2_M1);
    m2_bgrant_d = (state_d == ST_M2) || (state_d == ST_S1_M2);
    m1_split_d  = (state_d == ST_S1_IDLE) || (state_d == ST_S1_M2);
    m2_split_d  = (state_d == ST_S2_IDLE) || (state_d == ST_S2_M1);
    msel_d      = m2_bgrant_d ? MASTER_M2 : (m1_bgrant_d ? MASTER_M1 : msel_q);
    last_d      = m2_bgrant_d ? MASTER_M2 : (m1_bgrant_d ? MASTER_M1 : last_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      pend_q          <= 1'b0;
      last_q          <= MASTER_M2;
      msel_q          <= 1'b0;
      m1_bgrant_q     <= 1'b0;
      m2_bgrant_q     <= 1'b0;
      m1_split_q      <= 1'b0;
      m2_split_q      <= 1'b0;
      split_grant_q   <= 1'b0;
      split_timeout_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      pend_q          <= pend_d;
      last_q          <= last_d;
      msel_q          <= msel_d;
      m1_bgrant_q     <= m1_bgrant_d;
      m2_bgrant_q     <= m2_bgrant_d;
      m1_split_q      <= m1_split_d;
      m2_split_q      <= m2_split_d;
      split_grant_q   <= split_grant_d;
      split_timeout_q <= split_timeout_d;
    end
  end

  assign m1_bgrant     = m1_bgrant_q;
  assign m2_bgrant     = m2_bgrant_q;
  assign msel          = msel_q;
  assign m1_split      = m1_split_q;
  assign m2_split      = m2_split_q;
  assign split_grant   = split_grant_q;
  assign split_timeout = split_timeout_q;

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Bench for bus_split_arbiter: directed scenarios then random traffic, every
// cycle compared against an owner/suspended-master reference model.
module tb_bus_split_arbiter;

  localparam int TO = 16;

  logic clk = 1'b0;
  logic rstn, m1_breq, m2_breq, split, split_done;
  logic m1_bgrant, m2_bgrant, msel, m1_split, m2_split, split_grant, split_timeout;

  int errors = 0;
  int checks = 0;

  // Reference model: who owns the bus, who is suspended (0 = nobody).
  int owner, susp, tcnt, last;
  bit pend;
  bit e_g1, e_g2, e_msel, e_s1, e_s2, e_sg, e_to;

  always #5 clk = ~clk;

  bus_split_arbiter #(.SPLIT_TIMEOUT(TO), .TWIDTH(5)) dut (
    .clk(clk), .rstn(rstn),
    .m1_breq(m1_breq), .m2_breq(m2_breq),
    .split(split), .split_done(split_done),
    .m1_bgrant(m1_bgrant), .m2_bgrant(m2_bgrant), .msel(msel),
    .m1_split(m1_split), .m2_split(m2_split),
    .split_grant(split_grant), .split_timeout(split_timeout)
  );

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelReset();
    owner = 0; susp = 0; tcnt = 0; last = 2; pend = 0;
    e_g1 = 0; e_g2 = 0; e_msel = 0; e_s1 = 0; e_s2 = 0; e_sg = 0; e_to = 0;
  endtask

  task automatic modelStep(input bit b1, input bit b2, input bit sp, input bit sd);
    bit req[3];
    req[0] = 0; req[1] = b1; req[2] = b2;
    e_sg = 0; e_to = 0;
    if (susp != 0) begin
      if (tcnt == TO - 1) begin
        e_to = 1; susp = 0; pend = 0;
      end else begin
        tcnt++;
        if (owner == 0) begin
          if (sd) begin owner = susp; susp = 0; e_sg = 1; end
          else if (req[3 - susp]) owner = 3 - susp;
        end else begin
          if (sd) pend = 1;
          if (!req[owner]) begin
            if (pend) begin owner = susp; susp = 0; pend = 0; e_sg = 1; end
            else owner = 0;
          end
        end
      end
    end else if (owner == 0) begin
      if (b1 && b2) owner = (last == 2) ? 1 : 2;
      else if (b1)  owner = 1;
      else if (b2)  owner = 2;
    end else if (sp) begin
      susp = owner; owner = 0; tcnt = 0; pend = 0;
    end else if (!req[owner]) begin
      owner = 0;
    end
    if (owner != 0) begin
      last = owner;
      e_msel = (owner == 2);
    end
    e_g1 = (owner == 1); e_g2 = (owner == 2);
    e_s1 = (susp == 1);  e_s2 = (susp == 2);
  endtask

  task automatic checkAll();
    checkOutput("m1_bgrant", m1_bgrant, e_g1);
    checkOutput("m2_bgrant", m2_bgrant, e_g2);
    checkOutput("msel", msel, e_msel);
    checkOutput("m1_split", m1_split, e_s1);
    checkOutput("m2_split", m2_split, e_s2);
    checkOutput("split_grant", split_grant, e_sg);
    checkOutput("split_timeout", split_timeout, e_to);
  endtask

  task automatic applyStimulus(input bit b1, input bit b2, input bit sp, input bit sd);
    m1_breq = b1; m2_breq = b2; split = sp; split_done = sd;
    modelStep(b1, b2, sp, sd);
    @(posedge clk);
    #1;
    split = 0; split_done = 0;
    checkAll();
  endtask

  initial begin
    bit r1, r2;
    rstn = 0; m1_breq = 0; m2_breq = 0; split = 0; split_done = 0;
    modelReset();
    #12;
    checkAll();
    checkOutput("reset_msel", msel, 1'b0);

    // Release with both requesting: nothing granted before the first edge.
    @(posedge clk); #1;
    m1_breq = 1; m2_breq = 1; rstn = 1;
    checkAll();
    checkOutput("rel_no_grant", m1_bgrant | m2_bgrant, 1'b0);

    // Round-robin tie, release turnaround, msel hold.
    applyStimulus(1, 1, 0, 0);
    checkOutput("tie_m1_wins", m1_bgrant, 1'b1);
    checkOutput("tie_msel0", msel, 1'b0);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("turnaround_g2", m2_bgrant, 1'b0);
    applyStimulus(0, 1, 0, 0);
    checkOutput("m2_granted", m2_bgrant, 1'b1);
    checkOutput("m2_msel1", msel, 1'b1);
    applyStimulus(0, 0, 0, 0);
    checkOutput("msel_hold", msel, 1'b1);

    // Split in M1, master 2 takes bus, second split ignored, pending resume.
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0);
    checkOutput("split_s1", m1_split, 1'b1);
    checkOutput("split_g1_drop", m1_bgrant, 1'b0);
    applyStimulus(1, 1, 0, 0);
    checkOutput("s1m2_g2", m2_bgrant, 1'b1);
    applyStimulus(1, 1, 1, 0);
    checkOutput("split2_g2", m2_bgrant, 1'b1);
    checkOutput("split2_s2", m2_split, 1'b0);
    applyStimulus(1, 1, 0, 1);
    applyStimulus(1, 1, 0, 0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("resume_g1", m1_bgrant, 1'b1);
    checkOutput("resume_sg", split_grant, 1'b1);
    checkOutput("resume_s1", m1_split, 1'b0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("sg_one_cycle", split_grant, 1'b0);

    // Resume from S1_IDLE.
    applyStimulus(1, 0, 1, 0);
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 1);
    checkOutput("s1idle_resume_g1", m1_bgrant, 1'b1);
    checkOutput("s1idle_resume_sg", split_grant, 1'b1);
    applyStimulus(1, 0, 0, 0);

    // Timeout exactly TO cycles after entry.
    applyStimulus(1, 0, 1, 0);
    for (int k = 1; k <= TO; k++) begin
      applyStimulus(1, 0, 0, 0);
      if (k < TO) checkOutput("to_early", split_timeout, 1'b0);
    end
    checkOutput("to_pulse", split_timeout, 1'b1);
    checkOutput("to_s1_clear", m1_split, 1'b0);
    checkOutput("to_idle_g1", m1_bgrant, 1'b0);
    applyStimulus(1, 0, 0, 0);
    checkOutput("to_one_cycle", split_timeout, 1'b0);
    applyStimulus(0, 0, 0, 0);

    // Asynchronous reset while in S1_M2.
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0);
    applyStimulus(1, 1, 0, 0);
    #2;
    rstn = 0;
    modelReset();
    #1;
    checkAll();
    checkOutput("async_rst_g2", m2_bgrant, 1'b0);
    @(posedge clk); #1;
    rstn = 1;
    checkAll();
    applyStimulus(1, 1, 0, 0);
    checkOutput("post_rst_tie", m1_bgrant, 1'b1);
    applyStimulus(0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0);

    // Random traffic: masters hold breq until served, then release at random.
    r1 = 0; r2 = 0;
    for (int c = 0; c < 800; c++) begin
      if (!r1) r1 = ($urandom_range(2) == 0);
      else if (e_g1 && $urandom_range(3) == 0) r1 = 0;
      if (!r2) r2 = ($urandom_range(2) == 0);
      else if (e_g2 && $urandom_range(3) == 0) r2 = 0;
      applyStimulus(r1, r2, $urandom_range(5) == 0, $urandom_range(9) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_split_arbiter.md
BUS_SPLIT_ARBITER -- requirements
Module: bus_split_arbiter

Interface
REQ-001 SHALL have parameter SPLIT_TIMEOUT, default 4096: number of cycles a split master may stay suspended before it is aborted.
REQ-002 SHALL have parameter TWIDTH, default 13: suspension counter width; SHALL satisfy 2^TWIDTH > SPLIT_TIMEOUT.
REQ-003 SHALL have clk  in  1  single clock for all logic; all state changes on its rising edge.
REQ-004 SHALL have rstn  in  1  asynchronous reset, active-low.
REQ-005 SHALL have m1_breq, m2_breq  in  1 each  bus request, held high by a master for its whole transaction.
REQ-006 SHALL have split  in  1  one-cycle pulse from the addressed slave: suspend the current owner.
REQ-007 SHALL have split_done  in  1  one-cycle pulse from the split slave: data ready, resume the suspended master.
REQ-008 SHALL have m1_bgrant, m2_bgrant  out  1 each  bus grant, at most one high at any time.
REQ-009 SHALL have msel  out  1  bus mux select: 0 selects master 1, 1 selects master 2.
REQ-010 SHALL have m1_split, m2_split  out  1 each  high while that master is suspended.
REQ-011 SHALL have split_grant  out  1  one-cycle pulse to the slave when the suspended master is re-granted.
REQ-012 SHALL have split_timeout  out  1  one-cycle pulse when a suspension is aborted.

Function
REQ-013 SHALL implement the states IDLE, M1, M2, S1_IDLE, S1_M2, S2_IDLE and S2_M1; Sx_ means master x is suspended.
REQ-014 SHALL drive all outputs from registers; a grant rises one cycle after its breq is sampled high.
REQ-015 IDLE SHALL arbitrate round-robin: a sole requester wins; when both request, the master not granted last wins; the last-granted pointer resets to master 2, so master 1 wins the first tie.
REQ-016 SHALL make msel follow the granted master and hold its last value while no master is granted.
REQ-017 M1/M2 SHALL hold the grant while the owner's breq is high; on release SHALL go to IDLE for exactly one turnaround cycle with no grant.
REQ-018 split while in M1 SHALL go to S1_IDLE, drop m1_bgrant and raise m1_split; the M2 case is symmetric.
REQ-019 S1_IDLE SHALL grant master 2 (go to S1_M2) when m2_breq is high; m1_breq SHALL be ignored while master 1 is suspended.
REQ-020 split_done in S1_IDLE SHALL go to M1 next cycle: m1_bgrant high, m1_split low, split_grant pulsed.
REQ-021 split_done in S1_M2 SHALL set a pending flag; when m2_breq falls SHALL go straight to M1 (no turnaround) with split_grant pulsed.
REQ-022 split while already in S1_M2 or S2_M1 SHALL be ignored, because only one suspension is supported.
REQ-023 split in IDLE, and split_done with no master suspended, SHALL be ignored.
REQ-024 When split and a breq fall occur in the same cycle, split SHALL take priority.
REQ-025 SHALL count cycles spent in Sx_ states, clearing the count on entry.
REQ-026 When the count reaches SPLIT_TIMEOUT-1: SHALL pulse split_timeout, clear mx_split and the pending flag, and go S1_IDLE->IDLE, S1_M2->M2, S2_IDLE->IDLE, S2_M1->M1.
REQ-027 split_done arriving in the same cycle as the timeout SHALL be discarded; timeout wins.

Reset
REQ-028 When rstn is low: state IDLE; all grants, split flags, split_grant and split_timeout 0; msel 0; counter and pending flag 0; round-robin pointer set to master 2.
REQ-029 Reset asserted mid-transaction SHALL force the reset values immediately, without waiting for a clock edge.
REQ-030 SHALL grant nothing in the first cycle after reset release.

Structure
REQ-031 SHALL place the state encoding enum and master-ID constants (M1=0, M2=1) in the shared bus package used by the bus and the ports.
REQ-032 SHALL be a single module with no sub-modules; the suspension counter is inline.

Verification
REQ-033 Both breq rise together after reset -> m1_bgrant rises 1 cycle later with msel=0; on m1 release, one idle cycle, then m2_bgrant high with msel=1.
REQ-034 M1 owns the bus, split pulsed, m2_breq high -> m1_split=1, then m2_bgrant; split_done during M2 -> on m2 release, m1_bgrant next cycle, split_grant 1-cycle pulse, no idle gap.
REQ-035 S1_IDLE with split_done -> m1_bgrant=1, m1_split=0, split_grant=1 for one cycle.
REQ-036 SPLIT_TIMEOUT=16, split with no split_done -> split_timeout pulse exactly 16 cycles after entry, m1_split=0, state IDLE.
REQ-037 rstn pulled low while in S1_M2 -> all outputs 0 at once; after release no grant for 1 cycle.
REQ-038 A second split in S1_M2 -> ignored: m2_bgrant stays 1, m2_split stays 0.
